verificador_linhas: RTL

Sequencer that scans one 3x3 board stored in the board-state RAM and decides whether it is won by X, won by O, drawn, or still open. It is started by the game control unit in its verification step, once for the micro board just played and once for the macro board state. It drives the RAM read port (synchronous read, 1-cycle latency), walks the 8 winning lines, exits early on a win, and returns a registered result with a one-cycle `pronto` pulse.

---
 rtl/verificador_pkg.sv | 22 ++
 rtl/verificador_linhas_tabela.sv | 33 +++
 rtl/verificador_linhas.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/verificador_pkg.sv
// Shared cell codes, FSM state encodings and board limits
// for the line-checking sequencer.
package verificador_pkg;

  localparam int         N_LINHAS  = 8;
  localparam logic [3:0] TAB_MACRO = 4'd9;

  typedef enum logic [1:0] {
    VAZIO = 2'b00,
    X     = 2'b01,
    O     = 2'b10,
    BLOQ  = 2'b11
  } celula_t;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    LE     = 2'd1,
    AVALIA = 2'd2,
    FIM    = 2'd3
  } estado_t;

endpackage

// File: rtl/verificador_linhas_tabela.sv
// Combinational ROM: (line, position) -> row-major cell index
// of the 8 winning lines of a 3x3 board.
module tabela_linhas (
  input  logic [2:0] linha,
  input  logic [1:0] pos,
  output logic [3:0] celula
);

  logic [3:0] c0, c1, c2;

  always_comb begin
    c0 = 4'd0;
    c1 = 4'd0;
    c2 = 4'd0;
    case (linha)
      3'd0: {c0, c1, c2} = {4'd0, 4'd1, 4'd2};
      3'd1: {c0, c1, c2} = {4'd3, 4'd4, 4'd5};
      3'd2: {c0, c1, c2} = {4'd6, 4'd7, 4'd8};
      3'd3: {c0, c1, c2} = {4'd0, 4'd3, 4'd6};
      3'd4: {c0, c1, c2} = {4'd1, 4'd4, 4'd7};
      3'd5: {c0, c1, c2} = {4'd2, 4'd5, 4'd8};
      3'd6: {c0, c1, c2} = {4'd0, 4'd4, 4'd8};
      default: {c0, c1, c2} = {4'd2, 4'd4, 4'd6};
    endcase
    celula = c2;
    case (pos)
      2'd0:    celula = c0;
      2'd1:    celula = c1;
      default: celula = c2;
    endcase
  end

endmodule

// File: rtl/verificador_linhas.sv
// Scans one 3x3 board in RAM, line by line, and reports
// winner / draw / open with a one-cycle done pulse.
module verificador_linhas
  import verificador_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] tabuleiro_sel,
  input  logic [1:0] dado_mem,
  output logic       le_mem,
  output logic [3:0] endereco_tab,
  output logic [3:0] endereco_cel,
  output logic       ocupado,
  output logic       pronto,
  output logic [1:0] vencedor,
  output logic       empate,
  output logic       erro,
  output logic [3:0] db_estado
);

  estado_t    estado_q;
  logic [2:0] linha_q, linha_d;
  logic [1:0] pos_q, pos_d;
  logic [1:0] r0_q, r1_q;
  logic       vazia_q, vazia_d;
  logic [3:0] sel_q;
  logic       le_q, ocup_q, pronto_q;
  logic [3:0] cel_q, cel_d;
  logic [1:0] venc_q;
  logic       emp_q, erro_q;
  logic       ganhou;

  // ROM is addressed with the next (line, pos) so the
  // cell address is registered alongside the state.
  always_comb begin
    linha_d = linha_q;
    pos_d   = pos_q + 2'd1;
    if (estado_q == AVALIA) begin
      linha_d = linha_q + 3'd1;
      pos_d   = 2'd0;
    end else if (estado_q != LE) begin
      linha_d = 3'd0;
      pos_d   = 2'd0;
    end
  end

  tabela_linhas u_tabela (
    .linha  (linha_d),
    .pos    (pos_d),
    .celula (cel_d)
  );

  assign ganhou = (r0_q == r1_q) && (r1_q == dado_mem)
               && (r0_q == X || r0_q == O);

  assign vazia_d = vazia_q
                 | (r0_q == VAZIO)
                 | (r1_q == VAZIO)
                 | (dado_mem == VAZIO);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      linha_q  <= 3'd0;
      pos_q    <= 2'd0;
      r0_q     <= 2'd0;
      r1_q     <= 2'd0;
      vazia_q  <= 1'b0;
      sel_q    <= 4'd0;
      le_q     <= 1'b0;
      cel_q    <= 4'd0;
      ocup_q   <= 1'b0;
      pronto_q <= 1'b0;
      venc_q   <= 2'd0;
      emp_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        LE: begin
          pos_q <= pos_d;
          if (pos_q == 2'd1) r0_q <= dado_mem;
          if (pos_q == 2'd2) begin
            r1_q     <= dado_mem;
            le_q     <= 1'b0;
            estado_q <= AVALIA;
          end else begin
            cel_q <= cel_d;
          end
        end
        AVALIA: begin
          vazia_q <= vazia_d;
          if (ganhou) begin
            venc_q   <= r0_q;
            ocup_q   <= 1'b0;
            pronto_q <= 1'b1;
            estado_q <= FIM;
          end else if (linha_q == 3'(N_LINHAS - 1)) begin
            emp_q    <= ~vazia_d;
            ocup_q   <= 1'b0;
            pronto_q <= 1'b1;
            estado_q <= FIM;
          end else begin
            linha_q  <= linha_d;
            pos_q    <= 2'd0;
            le_q     <= 1'b1;
            cel_q    <= cel_d;
            estado_q <= LE;
          end
        end
        default: begin
          if (iniciar) begin
            sel_q   <= tabuleiro_sel;
            venc_q  <= 2'd0;
            emp_q   <= 1'b0;
            linha_q <= 3'd0;
            pos_q   <= 2'd0;
            vazia_q <= 1'b0;
            if (tabuleiro_sel > TAB_MACRO) begin
              erro_q   <= 1'b1;
              pronto_q <= 1'b1;
              estado_q <= FIM;
            end else begin
              erro_q   <= 1'b0;
              le_q     <= 1'b1;
              ocup_q   <= 1'b1;
              cel_q    <= cel_d;
              estado_q <= LE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    db_estado = 4'hE;
    case (estado_q)
      OCIOSO:  db_estado = 4'h0;
      LE:      db_estado = 4'h1;
      AVALIA:  db_estado = 4'h2;
      FIM:     db_estado = 4'h3;
      default: db_estado = 4'hE;
    endcase
  end

  assign le_mem       = le_q;
  assign endereco_tab = sel_q;
  assign endereco_cel = cel_q;
  assign ocupado      = ocup_q;
  assign pronto       = pronto_q;
  assign vencedor     = venc_q;
  assign empate       = emp_q;
  assign erro         = erro_q;

endmodule
